// File: rtl/port_rd_sequencer_pkg.sv
// port_rd_sequencer_pkg: shared sizes and FSM state type for the egress port read sequencer
package port_rd_sequencer_pkg;
    localparam int PRIOR_NUM = 8;
    localparam int PAGE_W = 11;
    localparam int PAGES_W = 7;
    typedef enum logic [2:0] {IDLE, HEAD, READ, LINK, DONE} state_e;
endpackage

// File: rtl/port_rd_sequencer.sv
// port_rd_sequencer: walks one queued packet's page chain from SRAM into the egress port
// clk/rst: clock, synchronous active-high reset
// queue_empty/prior_next/prior_update: dispatcher view and advance pulse
// hd_req/hd_prior/hd_valid/hd_page/hd_pages: queue-head fetch
// rd_req/rd_page/rd_ready: page read handshake
// lk_req/lk_addr/lk_valid/lk_next: link-list lookup
// port_ready/pkt_done/cur_prior: egress status
module port_rd_sequencer #(
    parameter int PRIOR_NUM = port_rd_sequencer_pkg::PRIOR_NUM,
    parameter int PRIOR_W = $clog2(PRIOR_NUM),
    parameter int PAGE_W = port_rd_sequencer_pkg::PAGE_W
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [PRIOR_NUM-1:0]                     queue_empty,
    input  logic [PRIOR_W-1:0]                       prior_next,
    output logic                                     prior_update,
    output logic                                     hd_req,
    output logic [PRIOR_W-1:0]                       hd_prior,
    input  logic                                     hd_valid,
    input  logic [PAGE_W-1:0]                        hd_page,
    input  logic [port_rd_sequencer_pkg::PAGES_W-1:0] hd_pages,
    output logic                                     rd_req,
    output logic [PAGE_W-1:0]                        rd_page,
    input  logic                                     rd_ready,
    output logic                                     lk_req,
    output logic [PAGE_W-1:0]                        lk_addr,
    input  logic                                     lk_valid,
    input  logic [PAGE_W-1:0]                        lk_next,
    input  logic                                     port_ready,
    output logic                                     pkt_done,
    output logic [PRIOR_W-1:0]                       cur_prior
);
    import port_rd_sequencer_pkg::*;
    state_e state_q, state_d;
    logic [PRIOR_W-1:0] prior_q, prior_d;
    logic [PAGE_W-1:0] page_q, page_d;
    logic [PAGES_W-1:0] remain_q, remain_d;
    logic [1:0] guard_q, guard_d;
    logic start, accept;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            prior_q <= '0;
            page_q <= '0;
            remain_q <= '0;
            guard_q <= '0;
        end else begin
            state_q <= state_d;
            prior_q <= prior_d;
            page_q <= page_d;
            remain_q <= remain_d;
            guard_q <= guard_d;
        end
    end
    // guard holds off a new start for two idle cycles so the dispatcher and queue_empty catch up
    always_comb begin
        start = state_q == IDLE && guard_q == 2'd0 && port_ready && !queue_empty[prior_next];
        accept = state_q == READ && port_ready && rd_ready;
        state_d = state_q;
        prior_d = prior_q;
        page_d = page_q;
        remain_d = remain_q;
        guard_d = (state_q == IDLE && guard_q != 2'd0) ? guard_q - 2'd1 : guard_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = HEAD;
                prior_d = prior_next;
            end
            HEAD: if (hd_valid) begin
                state_d = READ;
                page_d = hd_page;
                remain_d = (hd_pages == '0) ? PAGES_W'(1) : hd_pages;
            end
            READ: if (accept) begin
                state_d = (remain_q == PAGES_W'(1)) ? DONE : LINK;
                remain_d = remain_q - PAGES_W'(1);
            end
            LINK: if (lk_valid) begin
                state_d = READ;
                page_d = lk_next;
            end
            DONE: begin
                state_d = IDLE;
                guard_d = 2'd2;
            end
            default: state_d = IDLE;
        endcase
    end
    // every output is gated by rst so the block is silent during the reset cycle itself
    assign hd_req = !rst && start;
    assign hd_prior = hd_req ? prior_next : '0;
    assign rd_req = !rst && state_q == READ && port_ready;
    assign rd_page = (!rst && state_q == READ) ? page_q : '0;
    assign lk_req = !rst && accept && remain_q != PAGES_W'(1);
    assign lk_addr = lk_req ? page_q : '0;
    assign pkt_done = !rst && state_q == DONE;
    assign prior_update = pkt_done;
    assign cur_prior = rst ? '0 : prior_q;
endmodule

// File: tb/tb_port_rd_sequencer.sv
// tb_port_rd_sequencer: directed and randomized packet walks checked against per-packet expectations
module tb_port_rd_sequencer;
    logic clk, rst;
    logic [7:0] queue_empty;
    logic [2:0] prior_next, hd_prior, cur_prior;
    logic prior_update, hd_req, hd_valid, rd_req, rd_ready, lk_req, lk_valid, port_ready, pkt_done;
    logic [10:0] hd_page, rd_page, lk_addr, lk_next;
    logic [6:0] hd_pages;
    int checks = 0;
    int passes = 0;
    int lk_cnt = 0;
    int done_cnt = 0;
    logic [10:0] acc_q[$];
    logic [10:0] pq[$];

    port_rd_sequencer dut (
        .clk(clk), .rst(rst), .queue_empty(queue_empty), .prior_next(prior_next),
        .prior_update(prior_update), .hd_req(hd_req), .hd_prior(hd_prior),
        .hd_valid(hd_valid), .hd_page(hd_page), .hd_pages(hd_pages),
        .rd_req(rd_req), .rd_page(rd_page), .rd_ready(rd_ready),
        .lk_req(lk_req), .lk_addr(lk_addr), .lk_valid(lk_valid), .lk_next(lk_next),
        .port_ready(port_ready), .pkt_done(pkt_done), .cur_prior(cur_prior)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    // transaction monitor: sampled mid-cycle, after inputs settle and well before the rising edge
    always begin
        @(negedge clk);
        #2;
        if (rd_req && rd_ready) acc_q.push_back(rd_page);
        if (lk_req) lk_cnt++;
        if (pkt_done) done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_hd_req"}, hd_req, 0);
        chk({tag, "_hd_prior"}, hd_prior, 0);
        chk({tag, "_rd_req"}, rd_req, 0);
        chk({tag, "_rd_page"}, rd_page, 0);
        chk({tag, "_lk_req"}, lk_req, 0);
        chk({tag, "_lk_addr"}, lk_addr, 0);
        chk({tag, "_pkt_done"}, pkt_done, 0);
        chk({tag, "_prior_update"}, prior_update, 0);
        chk({tag, "_cur_prior"}, cur_prior, 0);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // randomizes everything the sequencer should ignore at this point of a packet
    task automatic quiet();
        rst = 0; hd_valid = 0; lk_valid = 0; rd_ready = 1; port_ready = 1;
        hd_page = 11'($urandom); hd_pages = 7'($urandom); lk_next = 11'($urandom);
        queue_empty = 8'($urandom); prior_next = 3'($urandom);
    endtask

    task automatic start_pkt(input logic [2:0] p);
        tick(); quiet();
        queue_empty = ~(8'd1 << p); prior_next = p;
        #1;
        chk("start_hd_req", hd_req, 1);
        chk("start_hd_prior", hd_prior, p);
        chk("start_rd_req", rd_req, 0);
    endtask

    task automatic head(input logic [2:0] p, input logic [10:0] page, input logic [6:0] npg, input int wait_n);
        for (int i = 0; i < wait_n; i++) begin
            tick(); quiet(); lk_valid = 1'($urandom);
            #1;
            chk("head_hd_req", hd_req, 0);
            chk("head_rd_req", rd_req, 0);
            chk("head_cur_prior", cur_prior, p);
        end
        tick(); quiet();
        hd_valid = 1; hd_page = page; hd_pages = npg;
        #1;
        chk("head_resp_rd_req", rd_req, 0);
    endtask

    task automatic read_page(input logic [10:0] page, input bit last, input int stall_n, input int drop_n);
        for (int i = 0; i < stall_n; i++) begin
            tick(); quiet(); hd_valid = 1'($urandom); lk_valid = 1'($urandom); rd_ready = 0;
            #1;
            chk("stall_rd_req", rd_req, 1);
            chk("stall_rd_page", rd_page, page);
            chk("stall_lk_req", lk_req, 0);
        end
        for (int i = 0; i < drop_n; i++) begin
            tick(); quiet(); port_ready = 0;
            #1;
            chk("drop_rd_req", rd_req, 0);
            chk("drop_lk_req", lk_req, 0);
        end
        tick(); quiet(); hd_valid = 1'($urandom); lk_valid = 1'($urandom);
        #1;
        chk("acc_rd_req", rd_req, 1);
        chk("acc_rd_page", rd_page, page);
        chk("acc_lk_req", lk_req, !last);
        chk("acc_lk_addr", lk_addr, last ? 11'd0 : page);
        chk("acc_pkt_done", pkt_done, 0);
    endtask

    task automatic link(input logic [10:0] nxt, input int wait_n);
        for (int i = 0; i < wait_n; i++) begin
            tick(); quiet(); hd_valid = 1'($urandom); rd_ready = 1'($urandom);
            #1;
            chk("link_lk_req", lk_req, 0);
            chk("link_rd_req", rd_req, 0);
        end
        tick(); quiet(); lk_valid = 1; lk_next = nxt;
        #1;
        chk("link_resp_rd_req", rd_req, 0);
    endtask

    task automatic done(input logic [2:0] p);
        tick(); quiet(); queue_empty = 8'h00; prior_next = p;
        #1;
        chk("done_pkt_done", pkt_done, 1);
        chk("done_prior_update", prior_update, 1);
        chk("done_cur_prior", cur_prior, p);
        chk("done_rd_req", rd_req, 0);
        chk("done_hd_req", hd_req, 0);
        for (int i = 0; i < 2; i++) begin
            tick(); quiet(); queue_empty = 8'h00; prior_next = p;
            #1;
            chk("guard_hd_req", hd_req, 0);
            chk("guard_pkt_done", pkt_done, 0);
            chk("guard_prior_update", prior_update, 0);
        end
    endtask

    task automatic run_pkt(input logic [2:0] p, input logic [10:0] pg[$], input logic [6:0] npg,
                           input bit rnd, input int at, input int stall_n, input int drop_n);
        int n;
        n = pg.size();
        acc_q.delete(); lk_cnt = 0; done_cnt = 0;
        start_pkt(p);
        head(p, pg[0], npg, rnd ? int'($urandom_range(0, 2)) : 0);
        for (int i = 0; i < n; i++) begin
            read_page(pg[i], i == n - 1,
                      i == at ? stall_n : (rnd ? int'($urandom_range(0, 2)) : 0),
                      i == at ? drop_n : (rnd ? int'($urandom_range(0, 1)) : 0));
            if (i < n - 1) link(pg[i + 1], rnd ? int'($urandom_range(0, 2)) : 0);
        end
        done(p);
        chk("acc_count", acc_q.size(), n);
        for (int i = 0; i < n && i < acc_q.size(); i++) chk("acc_order", acc_q[i], pg[i]);
        chk("lk_count", lk_cnt, n - 1);
        chk("done_count", done_cnt, 1);
    endtask

    initial begin
        rst = 1; queue_empty = 8'h00; prior_next = 3'd1; port_ready = 1; rd_ready = 1;
        hd_valid = 1; hd_page = 11'h155; hd_pages = 7'd3; lk_valid = 1; lk_next = 11'h2aa;
        for (int i = 0; i < 3; i++) begin
            tick(); #1;
            chk_zero("reset");
        end
        for (int i = 0; i < 100; i++) begin
            tick(); quiet(); queue_empty = 8'hff;
            #1;
            chk("idle_hd_req", hd_req, 0);
            chk("idle_rd_req", rd_req, 0);
            chk("idle_prior_update", prior_update, 0);
        end
        pq.delete(); pq.push_back(11'h015);
        run_pkt(3'd2, pq, 7'd1, 0, -1, 0, 0);
        chk("single_cur_prior", cur_prior, 2);
        pq.delete(); pq.push_back(11'h010); pq.push_back(11'h022); pq.push_back(11'h007);
        run_pkt(3'd4, pq, 7'd3, 0, 1, 4, 0);
        for (int i = 0; i < 5; i++) begin
            tick(); quiet(); queue_empty = 8'h00; port_ready = 0;
            #1;
            chk("noport_hd_req", hd_req, 0);
            chk("noport_rd_req", rd_req, 0);
        end
        pq.delete(); pq.push_back(11'h300); pq.push_back(11'h0ab);
        run_pkt(3'd6, pq, 7'd2, 0, 0, 0, 3);
        pq.delete(); pq.push_back(11'h1f0);
        run_pkt(3'd1, pq, 7'd0, 0, -1, 0, 0);
        acc_q.delete(); lk_cnt = 0; done_cnt = 0;
        start_pkt(3'd5);
        head(3'd5, 11'h100, 7'd2, 0);
        read_page(11'h100, 0, 0, 0);
        tick(); quiet(); rst = 1;
        #1;
        chk_zero("rst_link");
        pq.delete(); pq.push_back(11'h040); pq.push_back(11'h041);
        run_pkt(3'd3, pq, 7'd2, 0, -1, 0, 0);
        for (int k = 0; k < 25; k++) begin
            int n;
            logic [6:0] npg;
            n = $urandom_range(1, 5);
            pq.delete();
            for (int i = 0; i < n; i++) pq.push_back(11'($urandom));
            npg = (n == 1) ? 7'($urandom_range(0, 1)) : 7'(n);
            run_pkt(3'($urandom), pq, npg, 1, -1, 0, 0);
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
